// File: rtl/scarv_cpu_cop_if_if.sv
// Signal bundle for scarv_cpu_cop_if: CPU issue port, COP request/response port
// and CPU writeback port. master = the interface block, slave = its environment.
interface scarv_cpu_cop_if_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_insn;
    logic [31:0] issue_rs1;
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic        cpu_abort_req;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_gpr_wen;
    logic [4:0]  wb_gpr_addr;
    logic [31:0] wb_gpr_wdata;
    logic        wb_trap;
    logic [2:0]  wb_cause;
    logic        wb_timeout;
    logic        busy;

    modport master (
        input  issue_valid, issue_insn, issue_rs1, cop_insn_ack, cop_wen, cop_waddr,
               cop_wdata, cop_result, cop_insn_rsp, wb_ready,
        output issue_ready, cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1,
               cpu_insn_ack, wb_valid, wb_gpr_wen, wb_gpr_addr, wb_gpr_wdata,
               wb_trap, wb_cause, wb_timeout, busy
    );

    modport slave (
        output issue_valid, issue_insn, issue_rs1, cop_insn_ack, cop_wen, cop_waddr,
               cop_wdata, cop_result, cop_insn_rsp, wb_ready,
        input  issue_ready, cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1,
               cpu_insn_ack, wb_valid, wb_gpr_wen, wb_gpr_addr, wb_gpr_wdata,
               wb_trap, wb_cause, wb_timeout, busy
    );
endinterface

// File: rtl/scarv_cpu_cop_if.sv
// CPU <-> coprocessor instruction interface, one instruction in flight.
// Optional watchdog that abandons stalled instructions: SCARV_CPU_COP_TIMEOUT_EN.
module scarv_cpu_cop_if #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                g_clk,
    input  logic                g_reset,
    scarv_cpu_cop_if_if.master  bus
);

    // state | meaning
    // IDLE  | accepting a new instruction from the CPU
    // REQ   | cpu_insn_req high, waiting for cop_insn_ack
    // RSP   | cpu_insn_ack high, waiting for cop_insn_rsp
    // WB    | wb_valid high, waiting for wb_ready
    typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

    state_t      state_q;
    state_t      state_d;
    logic        ready_q;
    logic [31:0] insn_q;
    logic [31:0] rs1_q;
    logic        wb_wen_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        wb_trap_q;
    logic [2:0]  wb_cause_q;
    logic        issue_fire;
    logic        retire;
    logic        tmo_fire;

    assign bus.issue_ready  = ready_q && (state_q == IDLE);
    assign bus.cpu_insn_req = (state_q == REQ);
    assign bus.cpu_insn_ack = (state_q == RSP);
    assign bus.wb_valid     = (state_q == WB);
    assign bus.busy         = (state_q != IDLE);
    assign bus.cpu_insn_enc = insn_q;
    assign bus.cpu_rs1      = rs1_q;
    assign bus.wb_gpr_wen   = wb_wen_q;
    assign bus.wb_gpr_addr  = wb_addr_q;
    assign bus.wb_gpr_wdata = wb_data_q;
    assign bus.wb_trap      = wb_trap_q;
    assign bus.wb_cause     = wb_cause_q;

    assign issue_fire = bus.issue_valid && bus.issue_ready;
    assign retire     = (state_q == RSP) && bus.cop_insn_rsp;

`ifdef SCARV_CPU_COP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       abort_q;
    logic       wb_tmo_q;

    // Retirement in the terminal cycle wins over the watchdog.
    assign tmo_fire = ((state_q == REQ) || (state_q == RSP)) && (tmo_cnt_q == TMO_LAST) && !retire;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
            wb_tmo_q  <= 1'b0;
        end else begin
            if (issue_fire) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == REQ) || (state_q == RSP)) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            abort_q <= tmo_fire && (state_q == RSP);
            if (retire) begin
                wb_tmo_q <= 1'b0;
            end else if (tmo_fire) begin
                wb_tmo_q <= 1'b1;
            end
        end
    end

    assign bus.cpu_abort_req = abort_q;
    assign bus.wb_timeout    = wb_tmo_q;
`else
    assign tmo_fire          = 1'b0;
    assign bus.cpu_abort_req = 1'b0;
    assign bus.wb_timeout    = 1'b0;
`endif

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue_fire) state_d = REQ;
            REQ: begin
                if (tmo_fire) begin
                    state_d = WB;
                end else if (bus.cop_insn_ack) begin
                    state_d = RSP;
                end
            end
            RSP:  if (retire || tmo_fire) state_d = WB;
            WB:   if (bus.wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready_q keeps issue_ready low until the first clock after reset release.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            ready_q    <= 1'b0;
            insn_q     <= '0;
            rs1_q      <= '0;
            wb_wen_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_trap_q  <= 1'b0;
            wb_cause_q <= '0;
        end else begin
            ready_q <= 1'b1;
            if (issue_fire) begin
                insn_q <= bus.issue_insn;
                rs1_q  <= bus.issue_rs1;
            end
            if (retire) begin
                wb_wen_q   <= bus.cop_wen && (bus.cop_result == 3'd0);
                wb_addr_q  <= bus.cop_waddr;
                wb_data_q  <= bus.cop_wdata;
                wb_trap_q  <= (bus.cop_result != 3'd0);
                wb_cause_q <= bus.cop_result;
            end else if (tmo_fire) begin
                wb_wen_q   <= 1'b0;
                wb_addr_q  <= '0;
                wb_data_q  <= '0;
                wb_trap_q  <= 1'b1;
                wb_cause_q <= 3'b111;
            end
        end
    end

endmodule

// File: tb/tb_scarv_cpu_cop_if.sv
// Randomized bench for scarv_cpu_cop_if; outcomes come from a transaction-level
// model (delays, watchdog limit) rather than the cycle-level FSM.
module tb_scarv_cpu_cop_if;

    localparam int TMO = 8;

    logic g_clk;
    logic g_reset;
    int   n_checks;
    int   n_pass;

    scarv_cpu_cop_if_if bus ();

    scarv_cpu_cop_if #(.TIMEOUT_CYCLES(TMO)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.issue_valid  = 1'b0;
        bus.issue_insn   = '0;
        bus.issue_rs1    = '0;
        bus.cop_insn_ack = 1'b0;
        bus.cop_wen      = 1'b0;
        bus.cop_waddr    = '0;
        bus.cop_wdata    = '0;
        bus.cop_result   = '0;
        bus.cop_insn_rsp = 1'b0;
        bus.wb_ready     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue_ready"}, bus.issue_ready, 0);
        chk({tag, "_req"}, bus.cpu_insn_req, 0);
        chk({tag, "_abort"}, bus.cpu_abort_req, 0);
        chk({tag, "_ack"}, bus.cpu_insn_ack, 0);
        chk({tag, "_wb_valid"}, bus.wb_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_enc"}, bus.cpu_insn_enc, 0);
        chk({tag, "_rs1"}, bus.cpu_rs1, 0);
        chk({tag, "_wen"}, bus.wb_gpr_wen, 0);
        chk({tag, "_trap"}, bus.wb_trap, 0);
        chk({tag, "_tmo"}, bus.wb_timeout, 0);
        chk({tag, "_cause"}, bus.wb_cause, 0);
        chk({tag, "_addr"}, bus.wb_gpr_addr, 0);
        chk({tag, "_wdata"}, bus.wb_gpr_wdata, 0);
    endtask

    // One instruction: ack after ack_dly extra REQ cycles, rsp after rsp_dly extra
    // RSP cycles, wb_ready after wb_dly extra WB cycles.
    task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1,
                           input int ack_dly, input int rsp_dly, input int wb_dly,
                           input logic wen, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [2:0] res);
        int   cyc, req_n, ack_n, wb_n, abort_n, first_wb;
        int   exp_req_n, exp_ack_n, exp_wb_at, exp_abort_n;
        bit   done, tmo_exp;
        logic exp_wen, exp_trap;
        logic [2:0] exp_cause;

        tmo_exp     = 1'b0;
        exp_abort_n = 0;
        exp_req_n   = ack_dly + 1;
        exp_ack_n   = rsp_dly + 1;
`ifdef SCARV_CPU_COP_TIMEOUT_EN
        if (ack_dly + 1 >= TMO) begin
            tmo_exp   = 1'b1;
            exp_req_n = TMO;
            exp_ack_n = 0;
        end else if (ack_dly + rsp_dly + 2 > TMO) begin
            tmo_exp     = 1'b1;
            exp_abort_n = 1;
            exp_ack_n   = TMO - (ack_dly + 1);
        end
`endif
        exp_wb_at = 1 + exp_req_n + exp_ack_n;
        if (tmo_exp) begin
            exp_wen = 1'b0; exp_trap = 1'b1; exp_cause = 3'b111;
        end else begin
            exp_wen = wen && (res == 3'd0); exp_trap = (res != 3'd0); exp_cause = res;
        end

        @(negedge g_clk);
        chk("idle_ready", bus.issue_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_wb_valid", bus.wb_valid, 0);
        chk("idle_abort", bus.cpu_abort_req, 0);
        quiet_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_insn  = insn;
        bus.issue_rs1   = rs1;

        cyc = 0; req_n = 0; ack_n = 0; wb_n = 0; abort_n = 0; first_wb = -1; done = 1'b0;
        while (!done && cyc < 500) begin
            @(negedge g_clk);
            cyc++;
            chk("busy", bus.busy, 1);
            chk("issue_ready_busy", bus.issue_ready, 0);
            chk("enc_stable", bus.cpu_insn_enc, insn);
            chk("rs1_stable", bus.cpu_rs1, rs1);
            if (bus.cpu_abort_req) abort_n++;
            if (bus.cpu_insn_req) req_n++;
            if (bus.cpu_insn_ack) ack_n++;

            // Junk that must be ignored: new issues and stray responses.
            bus.issue_valid  = 1'($urandom_range(0, 1));
            bus.issue_insn   = $urandom;
            bus.issue_rs1    = $urandom;
            bus.cop_insn_ack = 1'b0;
            bus.wb_ready     = 1'b0;
            bus.cop_insn_rsp = 1'($urandom_range(0, 1));
            bus.cop_wen      = 1'($urandom_range(0, 1));
            bus.cop_waddr    = 5'($urandom);
            bus.cop_wdata    = $urandom;
            bus.cop_result   = 3'($urandom);

            if (bus.cpu_insn_req && req_n == ack_dly + 1) bus.cop_insn_ack = 1'b1;
            if (bus.cpu_insn_ack) begin
                bus.cop_insn_rsp = (ack_n == rsp_dly + 1);
                bus.cop_wen      = wen;
                bus.cop_waddr    = waddr;
                bus.cop_wdata    = wdata;
                bus.cop_result   = res;
            end
            if (bus.wb_valid) begin
                if (first_wb < 0) first_wb = cyc;
                wb_n++;
                chk("wb_gpr_wen", bus.wb_gpr_wen, exp_wen);
                chk("wb_trap", bus.wb_trap, exp_trap);
                chk("wb_cause", bus.wb_cause, exp_cause);
                chk("wb_timeout", bus.wb_timeout, tmo_exp);
                if (!tmo_exp) begin
                    chk("wb_gpr_addr", bus.wb_gpr_addr, waddr);
                    chk("wb_gpr_wdata", bus.wb_gpr_wdata, wdata);
                end
                if (wb_n == wb_dly + 1) begin
                    bus.wb_ready = 1'b1;
                    done = 1'b1;
                end
            end
        end
        chk("txn_done", done, 1);
        chk("req_cycles", req_n, exp_req_n);
        chk("ack_cycles", ack_n, exp_ack_n);
        chk("wb_latency", first_wb, exp_wb_at);
        chk("abort_pulses", abort_n, exp_abort_n);
    endtask

    // Reset while a response is being presented in RSP; optionally stall there first.
    task automatic reset_mid_rsp(input bit hang);
        @(negedge g_clk);
        chk("rst_idle_ready", bus.issue_ready, 1);
        quiet_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_insn  = 32'hCAFE_000B;
        bus.issue_rs1   = 32'h55AA_55AA;
        @(negedge g_clk);
        bus.issue_valid = 1'b0;
        chk("rst_req", bus.cpu_insn_req, 1);
        bus.cop_insn_ack = 1'b1;
        @(negedge g_clk);
        bus.cop_insn_ack = 1'b0;
        chk("rst_in_rsp", bus.cpu_insn_ack, 1);
        if (hang) begin
            for (int i = 0; i < 300; i++) begin
                @(negedge g_clk);
                chk("hang_busy", bus.busy, 1);
                chk("hang_ack", bus.cpu_insn_ack, 1);
                chk("hang_wb_valid", bus.wb_valid, 0);
            end
        end
        bus.cop_insn_rsp = 1'b1;
        bus.cop_wen      = 1'b1;
        bus.cop_waddr    = 5'd9;
        bus.cop_wdata    = 32'h1111_2222;
        #1 g_reset = 1'b1;
        #1 chk_all_zero("rst_async");
        @(negedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        chk("rst_release_ready", bus.issue_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            chk("post_rst_wb_valid", bus.wb_valid, 0);
            chk("post_rst_ack", bus.cpu_insn_ack, 0);
            chk("post_rst_abort", bus.cpu_abort_req, 0);
            chk("post_rst_ready", bus.issue_ready, 1);
        end
        quiet_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        quiet_inputs();
        g_reset = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        chk("release_ready", bus.issue_ready, 0);

        // fast path, exception, backpressure
        run_txn(32'h0000_100B, 32'h0000_1234, 0, 0, 0, 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0);
        run_txn(32'h0000_200B, 32'h0000_0042, 0, 0, 0, 1'b1, 5'd7, 32'h0BAD_F00D, 3'd1);
        run_txn(32'h0000_300B, 32'hA5A5_0001, 4, 1, 3, 1'b1, 5'd31, 32'h1234_5678, 3'd0);
        run_txn(32'h0000_400B, 32'h0000_0000, 0, 2, 0, 1'b0, 5'd3, 32'hFFFF_FFFF, 3'd0);
        // stalled response: completes late without the watchdog, abandoned with it
        run_txn(32'h0000_500B, 32'h0000_0077, 0, 20, 1, 1'b1, 5'd2, 32'h0000_0001, 3'd0);

        for (int t = 0; t < 40; t++) begin
            logic [2:0] r;
            r = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            run_txn($urandom, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom),
                    $urandom, r);
        end

`ifdef SCARV_CPU_COP_TIMEOUT_EN
        reset_mid_rsp(1'b0);
`else
        reset_mid_rsp(1'b1);
`endif
        run_txn(32'h0000_600B, 32'h0000_0099, 1, 0, 0, 1'b1, 5'd12, 32'hC0DE_C0DE, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
